regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 32x32 register file (`bancoDeRegistros`) between three writeback sources: ALU writeback, memory-load writeback and the debug loader. Requests are arbitrated round-robin, one write per enabled cycle, through a registered write stage that drives `we`/`addressW`/`data` of the register file. Read-address hazard flags let the decode stage stall while a write to a register it reads is queued or in flight.

## Interface
- `DATA_WIDTH`, 32, width of write data.
- `REGFILE_WIDTH`, 5, register address width (32 registers).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clkEnable`  in  1  global step enable; same signal that gates the register file write clock.
- `reqAlu`, `reqMem`, `reqDbg`  in  1 each  write request; held high with address/data until the matching grant.
- `addrAlu`, `addrMem`, `addrDbg`  in  REGFILE_WIDTH each  destination register per requester.
- `dataAlu`, `dataMem`, `dataDbg`  in  DATA_WIDTH each  write data per requester.
- `gntAlu`, `gntMem`, `gntDbg`  out  1 each  combinational one-hot grant; request consumed at this edge.
- `addressA`, `addressB`  in  REGFILE_WIDTH each  read addresses currently presented to the register file.
- `hazardA`, `hazardB`  out  1 each  combinational: pending write targets `addressA`/`addressB`.
- `we`  out  1  registered write enable to register file.
- `addressW`  out  REGFILE_WIDTH  registered write address.
- `data`  out  DATA_WIDTH  registered write data.
- `writeCount`  out  16  saturating count of committed non-zero-register writes.

## Operation
- Round-robin pointer FSM, states PRIO_ALU, PRIO_MEM, PRIO_DBG; search order starts at the pointer: ALU->MEM->DBG->ALU.
- Grant when `clkEnable`=1, `reset`=0 and at least one req high: first requester in search order; exactly one gnt high.
- After granting X, pointer moves to the state after X (ALU->PRIO_MEM, MEM->PRIO_DBG, DBG->PRIO_ALU). No grant: pointer holds.
- On grant edge the write stage loads granted address/data; `we`=1 unless address is 0.
- Address 0 ($zero): granted and consumed normally, `we`=0, `writeCount` not incremented.
- Enabled cycle with no grant: `we`<=0; `addressW`/`data` hold.
- `clkEnable`=0: all gnts 0, pointer, write stage and `writeCount` frozen; a stage holding `we`=1 commits on the first enabled edge.
- `writeCount` increments by 1 on each enabled edge where the stage loads a non-zero-address write; saturates at 16'hFFFF.
- `hazardA`=1 when `addressA`!=0 and equals either `addressW` with `we`=1, or the address of any requester with req high. Same rule for `hazardB` with `addressB`.
- Requester changing address/data while req is held is illegal. Dropping req before grant withdraws the request.

## Timing
- Reset values: `we`=0, `addressW`=0, `data`=0, `writeCount`=0, pointer PRIO_ALU. All gnts 0 while `reset`=1.
- Reset has priority over `clkEnable` and requests. Reset mid-operation discards the write stage; ungranted requests stay pending and are granted from PRIO_ALU after reset drops.
- Latency: request with gnt at edge N -> `we`/`addressW`/`data` valid cycle N+1 -> register file written at edge N+1 (enabled). Readable from edge N+1 on.
- Throughput: one write per enabled cycle. With all three requesting continuously each requester gets one grant every 3 enabled cycles; worst-case wait 2 grants.
- Simultaneous requests to the same register: both committed in grant order; last granted wins.

## Test plan
- Reset: hold `reset`=1 with all reqs high 2 cycles -> no gnts, `we`=0, `addressW`=0, `data`=0, `writeCount`=0; release -> `gntAlu` first.
- Single write: `reqMem`=1, `addrMem`=5, `dataMem`=32'hDEADBEEF -> `gntMem` same cycle; next cycle `we`=1, `addressW`=5, `data`=32'hDEADBEEF; register 5 reads 32'hDEADBEEF afterward; `writeCount`=1.
- Round-robin: all three request continuously (addresses 1, 2, 3) from PRIO_ALU -> grants ALU, MEM, DBG, ALU, MEM, DBG over 6 cycles; `writeCount`=6.
- $zero: `reqAlu` with `addrAlu`=0, data 32'h1234 -> `gntAlu`=1, next cycle `we`=0; register 0 stays 0; `writeCount` unchanged; `hazardA`=0 for `addressA`=0.
- clkEnable freeze: grant ALU addr 7, then `clkEnable`=0 for 4 cycles with `reqMem` high -> no gnts, `we`=1/`addressW`=7 held; re-enable -> reg 7 written, `gntMem` on that edge.
- Hazards: `reqDbg` addr 9 pending, `addressA`=9, `addressB`=10 -> `hazardA`=1, `hazardB`=0; `hazardA` stays 1 through write stage and clears the cycle after commit.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU,
// memory-load and debug-loader writeback sources, with a registered write
// stage and read-address hazard flags for the decode stage.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REGFILE_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clkEnable,
  input  logic                     reqAlu,
  input  logic                     reqMem,
  input  logic                     reqDbg,
  input  logic [REGFILE_WIDTH-1:0] addrAlu,
  input  logic [REGFILE_WIDTH-1:0] addrMem,
  input  logic [REGFILE_WIDTH-1:0] addrDbg,
  input  logic [DATA_WIDTH-1:0]    dataAlu,
  input  logic [DATA_WIDTH-1:0]    dataMem,
  input  logic [DATA_WIDTH-1:0]    dataDbg,
  output logic                     gntAlu,
  output logic                     gntMem,
  output logic                     gntDbg,
  input  logic [REGFILE_WIDTH-1:0] addressA,
  input  logic [REGFILE_WIDTH-1:0] addressB,
  output logic                     hazardA,
  output logic                     hazardB,
  output logic                     we,
  output logic [REGFILE_WIDTH-1:0] addressW,
  output logic [DATA_WIDTH-1:0]    data,
  output logic [15:0]              writeCount
);

  localparam int unsigned NUM_REQ     = 3;
  localparam int unsigned COUNT_WIDTH = 16;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [REGFILE_WIDTH-1:0] ZERO_REG = '0;

  // Bit positions of each requester in the request/grant vectors.
  localparam int unsigned IDX_ALU = 0;
  localparam int unsigned IDX_MEM = 1;
  localparam int unsigned IDX_DBG = 2;

  typedef struct packed {
    logic [REGFILE_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
  } wr_req_t;

  typedef enum logic [1:0] {
    PRIO_ALU = 2'd0,
    PRIO_MEM = 2'd1,
    PRIO_DBG = 2'd2
  } prio_e;

  prio_e                state;
  prio_e                state_next;
  logic [NUM_REQ-1:0]   req_vec;
  logic [NUM_REQ-1:0]   gnt_vec;
  logic                 grant_any;
  wr_req_t              granted;
  logic                 granted_nonzero;

  assign req_vec = {reqDbg, reqMem, reqAlu};

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRIO_ALU;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection in search order from the pointer, and pointer advance past the winner.
  always_comb begin
    state_next = state;
    gnt_vec    = '0;
    if (!reset && clkEnable) begin
      case (state)
        PRIO_ALU: begin
          if (req_vec[IDX_ALU])      gnt_vec[IDX_ALU] = 1'b1;
          else if (req_vec[IDX_MEM]) gnt_vec[IDX_MEM] = 1'b1;
          else if (req_vec[IDX_DBG]) gnt_vec[IDX_DBG] = 1'b1;
        end
        PRIO_MEM: begin
          if (req_vec[IDX_MEM])      gnt_vec[IDX_MEM] = 1'b1;
          else if (req_vec[IDX_DBG]) gnt_vec[IDX_DBG] = 1'b1;
          else if (req_vec[IDX_ALU]) gnt_vec[IDX_ALU] = 1'b1;
        end
        PRIO_DBG: begin
          if (req_vec[IDX_DBG])      gnt_vec[IDX_DBG] = 1'b1;
          else if (req_vec[IDX_ALU]) gnt_vec[IDX_ALU] = 1'b1;
          else if (req_vec[IDX_MEM]) gnt_vec[IDX_MEM] = 1'b1;
        end
        default: gnt_vec = '0;
      endcase
      if (gnt_vec[IDX_ALU])      state_next = PRIO_MEM;
      else if (gnt_vec[IDX_MEM]) state_next = PRIO_DBG;
      else if (gnt_vec[IDX_DBG]) state_next = PRIO_ALU;
    end
  end

  assign gntAlu    = gnt_vec[IDX_ALU];
  assign gntMem    = gnt_vec[IDX_MEM];
  assign gntDbg    = gnt_vec[IDX_DBG];
  assign grant_any = |gnt_vec;

  // Payload of the granted requester (grant is one-hot).
  always_comb begin
    granted = '0;
    if (gnt_vec[IDX_ALU]) begin
      granted.addr  = addrAlu;
      granted.wdata = dataAlu;
    end else if (gnt_vec[IDX_MEM]) begin
      granted.addr  = addrMem;
      granted.wdata = dataMem;
    end else if (gnt_vec[IDX_DBG]) begin
      granted.addr  = addrDbg;
      granted.wdata = dataDbg;
    end
  end

  // Writes to $zero are consumed but never enabled nor counted.
  assign granted_nonzero = (granted.addr != ZERO_REG);

  // Registered write stage and saturating commit counter, frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      we         <= 1'b0;
      addressW   <= '0;
      data       <= '0;
      writeCount <= '0;
    end else if (clkEnable) begin
      if (grant_any) begin
        we       <= granted_nonzero;
        addressW <= granted.addr;
        data     <= granted.wdata;
        if (granted_nonzero && (writeCount != COUNT_MAX)) begin
          writeCount <= writeCount + COUNT_WIDTH'(1);
        end
      end else begin
        we <= 1'b0;
      end
    end
  end

  // Read-after-write hazard: read address matches the write stage or any live request.
  function automatic logic pending_hit(input logic [REGFILE_WIDTH-1:0] raddr);
    logic hit;
    hit = 1'b0;
    if (raddr != ZERO_REG) begin
      hit = (we     && (addressW == raddr)) ||
            (reqAlu && (addrAlu  == raddr)) ||
            (reqMem && (addrMem  == raddr)) ||
            (reqDbg && (addrDbg  == raddr));
    end
    return hit;
  endfunction

  assign hazardA = pending_hit(addressA);
  assign hazardB = pending_hit(addressB);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table-driven vectors with a write-stage
// scoreboard and a behavioural register file fed by the write port.
module tb_regfile_write_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic          clkEnable;
  logic          reqAlu, reqMem, reqDbg;
  logic [AW-1:0] addrAlu, addrMem, addrDbg;
  logic [DW-1:0] dataAlu, dataMem, dataDbg;
  logic          gntAlu, gntMem, gntDbg;
  logic [AW-1:0] addressA, addressB;
  logic          hazardA, hazardB;
  logic          we;
  logic [AW-1:0] addressW;
  logic [DW-1:0] data;
  logic [15:0]   writeCount;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .REGFILE_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .clkEnable(clkEnable),
    .reqAlu(reqAlu), .reqMem(reqMem), .reqDbg(reqDbg),
    .addrAlu(addrAlu), .addrMem(addrMem), .addrDbg(addrDbg),
    .dataAlu(dataAlu), .dataMem(dataMem), .dataDbg(dataDbg),
    .gntAlu(gntAlu), .gntMem(gntMem), .gntDbg(gntDbg),
    .addressA(addressA), .addressB(addressB),
    .hazardA(hazardA), .hazardB(hazardB),
    .we(we), .addressW(addressW), .data(data), .writeCount(writeCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic [2:0]    req;   // {dbg, mem, alu}
    logic [AW-1:0] aa, am, ad;
    logic [DW-1:0] da, dm, dd;
    logic [AW-1:0] ra, rb;
    logic [2:0]    gnt;   // expected {dbg, mem, alu}
    logic          hza, hzb;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          wen;
  } exp_wr_t;

  exp_wr_t       sb[$];
  vec_t          tbl[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] rf [32];
  logic          e_we;
  logic [AW-1:0] e_aw;
  logic [DW-1:0] e_d;
  logic [15:0]   e_cnt;

  // Behavioural register file: written on enabled edges while we is high.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) begin
    if (clkEnable === 1'b1 && we === 1'b1) rf[addressW] = data;
  end

  function automatic vec_t mk(input logic rst, input logic en, input logic [2:0] req,
                              input logic [AW-1:0] aa, input logic [AW-1:0] am, input logic [AW-1:0] ad,
                              input logic [DW-1:0] da, input logic [DW-1:0] dm, input logic [DW-1:0] dd,
                              input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                              input logic [2:0] gnt, input logic hza, input logic hzb);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req;
    v.aa = aa; v.am = am; v.ad = ad;
    v.da = da; v.dm = dm; v.dd = dd;
    v.ra = ra; v.rb = rb;
    v.gnt = gnt; v.hza = hza; v.hzb = hzb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Drive one vector, check combinational outputs, clock it, check the write stage.
  task automatic apply(input vec_t v, input string tag);
    exp_wr_t w;
    logic    pushed;
    reset = v.rst; clkEnable = v.en;
    {reqDbg, reqMem, reqAlu} = v.req;
    addrAlu = v.aa; addrMem = v.am; addrDbg = v.ad;
    dataAlu = v.da; dataMem = v.dm; dataDbg = v.dd;
    addressA = v.ra; addressB = v.rb;
    #2;
    chk({tag, " gnt"}, 32'({gntDbg, gntMem, gntAlu}), 32'(v.gnt));
    chk({tag, " hazardA"}, 32'(hazardA), 32'(v.hza));
    chk({tag, " hazardB"}, 32'(hazardB), 32'(v.hzb));
    pushed = 1'b0;
    w = '{addr: '0, dat: '0, wen: 1'b0};
    if (v.rst) begin
      e_we = 1'b0; e_aw = '0; e_d = '0; e_cnt = '0;
      sb.delete();
    end else if (v.en) begin
      if (v.gnt != 3'b000) begin
        case (v.gnt)
          3'b001:  w = '{addr: v.aa, dat: v.da, wen: (v.aa != '0)};
          3'b010:  w = '{addr: v.am, dat: v.dm, wen: (v.am != '0)};
          default: w = '{addr: v.ad, dat: v.dd, wen: (v.ad != '0)};
        endcase
        sb.push_back(w);
        pushed = 1'b1;
        e_we = w.wen; e_aw = w.addr; e_d = w.dat;
        if (w.wen && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      end else begin
        e_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (pushed && sb.size() > 0) begin
      w = sb.pop_front();
      chk({tag, " sb addressW"}, 32'(addressW), 32'(w.addr));
      chk({tag, " sb data"}, data, w.dat);
      chk({tag, " sb we"}, 32'(we), 32'(w.wen));
    end else begin
      chk({tag, " we"}, 32'(we), 32'(e_we));
      chk({tag, " addressW"}, 32'(addressW), 32'(e_aw));
      chk({tag, " data"}, data, e_d);
    end
    chk({tag, " writeCount"}, 32'(writeCount), 32'(e_cnt));
  endtask

  initial begin
    e_we = 1'b0; e_aw = '0; e_d = '0; e_cnt = '0;

    // Reset with all requesters active, release, then round-robin over 6 cycles.
    tbl.push_back(mk(1,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 0,0, 3'b000, 0,0));
    tbl.push_back(mk(1,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 0,0, 3'b000, 0,0));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 0,0, 3'b001, 0,0));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 0,0, 3'b010, 0,0));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 0,0, 3'b100, 0,0));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 2,3, 3'b001, 1,1));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 4,0, 3'b010, 0,0));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'hA1,32'hB2,32'hC3, 0,0, 3'b100, 0,0));
    // Idle: stage (addr 3) still visible as a hazard, dropped requests are not.
    tbl.push_back(mk(0,1,3'b000, 1,2,3, 32'hA1,32'hB2,32'hC3, 3,2, 3'b000, 1,0));
    // Reset, then single memory write to r5.
    tbl.push_back(mk(1,1,3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0,0));
    tbl.push_back(mk(0,1,3'b010, 0,5,0, 0,32'hDEADBEEF,0, 0,0, 3'b010, 0,0));
    tbl.push_back(mk(0,1,3'b000, 0,5,0, 0,32'hDEADBEEF,0, 5,0, 3'b000, 1,0));
    // $zero write: granted, we stays low, count unchanged.
    tbl.push_back(mk(0,1,3'b001, 0,0,0, 32'h1234,0,0, 0,0, 3'b001, 0,0));
    tbl.push_back(mk(0,1,3'b000, 0,0,0, 32'h1234,0,0, 0,0, 3'b000, 0,0));
    // Hazard on r9: pending while disabled, granted, in stage, cleared after commit.
    tbl.push_back(mk(0,0,3'b100, 0,0,9, 0,0,32'h99, 9,10, 3'b000, 1,0));
    tbl.push_back(mk(0,1,3'b100, 0,0,9, 0,0,32'h99, 9,10, 3'b100, 1,0));
    tbl.push_back(mk(0,1,3'b000, 0,0,9, 0,0,32'h99, 9,10, 3'b000, 1,0));
    tbl.push_back(mk(0,1,3'b000, 0,0,9, 0,0,32'h99, 9,10, 3'b000, 0,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    chk("rf5", rf[5], 32'hDEADBEEF);
    chk("rf0", rf[0], 32'h0);
    chk("rf9", rf[9], 32'h99);

    // clkEnable freeze: stage holding r7 waits, pending MEM granted on re-enable.
    apply(mk(0,1,3'b001, 7,8,0, 32'h77,32'h88,0, 7,8, 3'b001, 1,0), "f1");
    for (int i = 0; i < 4; i++)
      apply(mk(0,0,3'b010, 7,8,0, 32'h77,32'h88,0, 7,8, 3'b000, 1,1), $sformatf("f%0d", i + 2));
    chk("rf7 frozen", rf[7], 32'h0);
    apply(mk(0,1,3'b010, 7,8,0, 32'h77,32'h88,0, 7,8, 3'b010, 1,1), "f6");
    chk("rf7 commit", rf[7], 32'h77);

    // Reset mid-operation: pointer returns to PRIO_ALU, pending requests survive.
    apply(mk(0,1,3'b010, 11,12,13, 32'h11A,32'h12C,32'h13D, 0,0, 3'b010, 0,0), "r1");
    apply(mk(1,1,3'b101, 11,12,13, 32'h11A,32'h12C,32'h13D, 0,0, 3'b000, 0,0), "r2");
    apply(mk(0,1,3'b101, 11,12,13, 32'h11A,32'h12C,32'h13D, 0,0, 3'b001, 0,0), "r3");
    apply(mk(0,1,3'b100, 11,12,13, 32'h11A,32'h12C,32'h13D, 0,0, 3'b100, 0,0), "r4");
    apply(mk(0,1,3'b000, 11,12,13, 32'h11A,32'h12C,32'h13D, 0,0, 3'b000, 0,0), "r5");
    chk("rf11", rf[11], 32'h11A);
    chk("rf13", rf[13], 32'h13D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
